// File: rtl/demux_int_pkg.sv
// Shared definitions for the demux_int block: default queue geometry,
// the pointer-width constant and the destination encoding.
package demux_int_pkg;

  // Default data word width and entries per output queue.
  localparam int DEMUX_INT_WIDTH = 32;
  localparam int DEMUX_INT_DEPTH = 4;

  // Pointer width for a queue of the given power-of-two depth. A depth of 2
  // still needs one pointer bit, so the result never drops below 1.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Pointer width for the default depth.
  localparam int DEMUX_INT_PTR_W = ptr_width(DEMUX_INT_DEPTH);

  // Destination select values carried on in_dest.
  typedef enum logic {
    DEST_PORT1 = 1'b0,
    DEST_PORT2 = 1'b1
  } dest_e;

endpackage

// File: rtl/demux_int_fifo.sv
// Single output queue of the demux: circular buffer with registered count,
// registered full flag and a head word that reads 0 while the queue is empty.
// A push is refused whenever the registered full flag is set, even if a pop
// happens in the same cycle.
module demux_int_fifo
  import demux_int_pkg::*;
#(
  parameter int DEPTH = DEMUX_INT_DEPTH,
  parameter int WIDTH = DEMUX_INT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [0:WIDTH-1] i_data,
  input  logic             i_pop,
  output logic [0:WIDTH-1] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic [0:WIDTH-1] r_mem [DEPTH];

  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Qualify requests: pushes only when not full at cycle start, pops only
  // when something is stored (an ack on an empty queue is ignored).
  always_comb begin
    w_empty = (r_count == '0);
    w_push  = i_push & ~r_full;
    w_pop   = i_pop & ~w_empty;
  end

  // Next occupancy; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count and full flag; reset discards all queued words at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_MAX);
    end
  end

  // Storage array; contents are never cleared, the head mux hides stale data.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Head word and status presented to the downstream side.
  always_comb begin
    o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    o_empty = w_empty;
    o_full  = r_full;
  end

endmodule

// File: rtl/demux_int.sv
// Two-way demultiplexer with an output queue per destination.
//
// Handshakes: the upstream source holds in_sel/in_dest/in_data stable until
// in_resp is 1; a word transfers on a rising edge where in_resp is 1.
// Downstream N sees out_selN=1 while queue N holds a word and consumes the
// head on a rising edge where out_selN and out_ackN are both 1.
module demux_int
  import demux_int_pkg::*;
#(
  parameter int DEPTH = DEMUX_INT_DEPTH,
  parameter int WIDTH = DEMUX_INT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [0:WIDTH-1] in_data,
  input  logic             in_sel,
  input  logic             in_dest,
  output logic             in_resp,
  output logic [0:WIDTH-1] out_data1,
  output logic             out_sel1,
  input  logic             out_ack1,
  output logic [0:WIDTH-1] out_data2,
  output logic             out_sel2,
  input  logic             out_ack2,
  output logic [0:1]       out_full
);

  logic             w_full1;
  logic             w_full2;
  logic             w_empty1;
  logic             w_empty2;
  logic             w_target_full;
  logic             w_accept;
  logic             w_push1;
  logic             w_push2;
  logic [0:WIDTH-1] w_head1;
  logic [0:WIDTH-1] w_head2;

  // Acceptance: the addressed queue must not be full at cycle start, and
  // nothing is accepted while reset is held.
  always_comb begin
    w_target_full = (dest_e'(in_dest) == DEST_PORT2) ? w_full2 : w_full1;
    w_accept      = in_sel & ~w_target_full & ~reset;
    w_push1       = w_accept & (dest_e'(in_dest) == DEST_PORT1);
    w_push2       = w_accept & (dest_e'(in_dest) == DEST_PORT2);
  end

  demux_int_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo1 (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push1),
    .i_data  (in_data),
    .i_pop   (out_ack1),
    .o_head  (w_head1),
    .o_empty (w_empty1),
    .o_full  (w_full1)
  );

  demux_int_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo2 (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push2),
    .i_data  (in_data),
    .i_pop   (out_ack2),
    .o_head  (w_head2),
    .o_empty (w_empty2),
    .o_full  (w_full2)
  );

  // Output mapping; out_full bit 0 is queue 1, bit 1 is queue 2.
  always_comb begin
    in_resp   = w_accept;
    out_data1 = w_head1;
    out_sel1  = ~w_empty1;
    out_data2 = w_head2;
    out_sel2  = ~w_empty2;
    out_full  = {w_full1, w_full2};
  end

endmodule

// File: tb/tb_demux_int.sv
// Bench for demux_int: directed scenarios followed by a long randomized run.
// A negedge scoreboard keeps one expected-word queue per destination and
// checks acceptance, head data, valid and full flags every cycle.
module tb_demux_int;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [0:WIDTH-1] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_dest = 1'b0;
  logic             in_resp;
  logic [0:WIDTH-1] out_data1;
  logic             out_sel1;
  logic             out_ack1 = 1'b0;
  logic [0:WIDTH-1] out_data2;
  logic             out_sel2;
  logic             out_ack2 = 1'b0;
  logic [0:1]       out_full;

  always #5 clock = ~clock;

  demux_int #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_dest   (in_dest),
    .in_resp   (in_resp),
    .out_data1 (out_data1),
    .out_sel1  (out_sel1),
    .out_ack1  (out_ack1),
    .out_data2 (out_data2),
    .out_sel2  (out_sel2),
    .out_ack2  (out_ack2),
    .out_full  (out_full)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q1[$];
  logic [WIDTH-1:0] exp_q2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each queue is a list of accepted words; an offer is
  // taken when the addressed list holds fewer than DEPTH words at cycle
  // start; an ack removes the oldest word if there is one.
  always @(negedge clock) begin : monitor
    int s1;
    int s2;
    logic exp_resp;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    if (reset) begin
      check("rst_sel1", out_sel1, 1'b0);
      check("rst_sel2", out_sel2, 1'b0);
      check("rst_full", out_full, 2'b00);
      check("rst_data1", out_data1, '0);
      check("rst_data2", out_data2, '0);
      check("rst_resp", in_resp, 1'b0);
      exp_q1.delete();
      exp_q2.delete();
    end else begin
      s1 = exp_q1.size();
      s2 = exp_q2.size();
      exp_resp = in_sel && ((in_dest ? s2 : s1) < DEPTH);
      e1 = (s1 != 0) ? exp_q1[0] : '0;
      e2 = (s2 != 0) ? exp_q2[0] : '0;
      check("in_resp", in_resp, exp_resp);
      check("out_sel1", out_sel1, s1 != 0);
      check("out_sel2", out_sel2, s2 != 0);
      check("out_data1", out_data1, e1);
      check("out_data2", out_data2, e2);
      check("out_full1", out_full[0], s1 == DEPTH);
      check("out_full2", out_full[1], s2 == DEPTH);
      if (out_ack1 && s1 != 0) void'(exp_q1.pop_front());
      if (out_ack2 && s2 != 0) void'(exp_q2.pop_front());
      if (exp_resp) begin
        if (in_dest) exp_q2.push_back(in_data);
        else         exp_q1.push_back(in_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic sel, input logic dest, input logic [WIDTH-1:0] data);
    in_sel  = sel;
    in_dest = dest;
    in_data = data;
  endtask

  task automatic drain();
    in_sel   = 1'b0;
    out_ack1 = 1'b1;
    out_ack2 = 1'b1;
    repeat (DEPTH + 2) tick();
    out_ack1 = 1'b0;
    out_ack2 = 1'b0;
    #1;
    check("drain_sel1", out_sel1, 1'b0);
    check("drain_sel2", out_sel2, 1'b0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic holding;
    logic accepted;
    int   pct1;
    int   pct2;

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single word to port 1.
    set_in(1'b1, 1'b0, 32'hA5A5_0001);
    #1;
    check("t34_resp", in_resp, 1'b1);
    tick();
    set_in(1'b0, 1'b0, '0);
    check("t34_sel1", out_sel1, 1'b1);
    check("t34_data1", out_data1, 32'hA5A5_0001);
    check("t34_sel2", out_sel2, 1'b0);
    drain();

    // Fill port 2, hold a fifth offer, free one slot.
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 1'b1, WIDTH'(i));
      tick();
    end
    set_in(1'b1, 1'b1, 32'h0000_0005);
    #1;
    check("t35_full2", out_full[1], 1'b1);
    check("t35_full1", out_full[0], 1'b0);
    check("t35_refuse", in_resp, 1'b0);
    tick();
    check("t35_held", in_resp, 1'b0);
    out_ack2 = 1'b1;
    tick();
    out_ack2 = 1'b0;
    #1;
    check("t35_accept", in_resp, 1'b1);
    tick();
    in_sel = 1'b0;
    check("t35_full_again", out_full[1], 1'b1);
    drain();

    // Full queue 1: push during a pop is refused, retry succeeds.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 32'h0000_3600 + WIDTH'(i));
      tick();
    end
    out_ack1 = 1'b1;
    set_in(1'b1, 1'b0, 32'h0000_36AA);
    #1;
    check("t36_refuse", in_resp, 1'b0);
    tick();
    out_ack1 = 1'b0;
    #1;
    check("t36_not_full", out_full[0], 1'b0);
    check("t36_retry", in_resp, 1'b1);
    tick();
    in_sel = 1'b0;
    check("t36_full", out_full[0], 1'b1);
    drain();

    // Count 2 with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 32'h0000_0A00 + WIDTH'(i));
      tick();
    end
    out_ack1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b0, 32'h0000_00C3 + WIDTH'(i));
      tick();
    end
    in_sel   = 1'b0;
    out_ack1 = 1'b0;
    #1;
    check("t37_sel1", out_sel1, 1'b1);
    check("t37_not_full", out_full[0], 1'b0);
    check("t37_head", out_data1, 32'h0000_00CB);
    drain();

    // Asynchronous reset between edges with both queues occupied.
    set_in(1'b1, 1'b0, 32'h0000_1111); tick();
    set_in(1'b1, 1'b1, 32'h0000_2222); tick();
    set_in(1'b1, 1'b0, 32'h0000_3333); tick();
    set_in(1'b1, 1'b1, 32'h0000_4444); tick();
    in_sel = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t38_sel1", out_sel1, 1'b0);
    check("t38_sel2", out_sel2, 1'b0);
    check("t38_full", out_full, 2'b00);
    check("t38_data1", out_data1, '0);
    set_in(1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
    tick();
    reset = 1'b0;
    tick();
    in_sel = 1'b0;
    check("t38_first_sel", out_sel1, 1'b1);
    check("t38_first_data", out_data1, 32'hDEAD_BEEF);
    drain();

    // Randomized interleaving with varying ack density.
    holding = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      case (c / 2500)
        0:       begin pct1 = 50; pct2 = 50; end
        1:       begin pct1 = 10; pct2 = 10; end
        2:       begin pct1 = 90; pct2 = 90; end
        default: begin pct1 = 85; pct2 = 15; end
      endcase
      if (!holding) begin
        in_sel  = ($urandom_range(0, 9) < 7);
        in_dest = 1'($urandom_range(0, 1));
        in_data = $urandom;
      end
      out_ack1 = ($urandom_range(0, 99) < pct1);
      out_ack2 = ($urandom_range(0, 99) < pct2);
      @(negedge clock);
      accepted = in_resp;
      holding  = in_sel && !accepted;
      @(posedge clock);
      #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
